// File: rtl/insn_fetch_pkg.sv
// rtl/insn_fetch_pkg.sv - shared state, step and operand-count definitions for the instruction fetcher
package insn_fetch_pkg;

    localparam int ADDR_W_DEF = 16;

    typedef enum logic [2:0] {
        ST_BOOT = 3'd0,
        ST_OP   = 3'd1,
        ST_LEN  = 3'd2,
        ST_OPND = 3'd3,
        ST_HOLD = 3'd4
    } state_t;

    localparam logic [2:0] IS_BOOT = 3'd0;
    localparam logic [2:0] IS_OP   = 3'd1;
    localparam logic [2:0] IS_LEN  = 3'd2;
    localparam logic [2:0] IS_OPND = 3'd2;  // operand k reports IS_OPND + k (3..5)
    localparam logic [2:0] IS_HOLD = 3'd6;

    localparam logic [1:0] LEN_0 = 2'd0;
    localparam logic [1:0] LEN_1 = 2'd1;
    localparam logic [1:0] LEN_2 = 2'd2;
    localparam logic [1:0] LEN_3 = 2'd3;

    function automatic logic [2:0] step_code(input state_t s, input logic [1:0] k);
        case (s)
            ST_BOOT: step_code = IS_BOOT;
            ST_OP:   step_code = IS_OP;
            ST_LEN:  step_code = IS_LEN;
            ST_OPND: step_code = IS_OPND + {1'b0, k};
            ST_HOLD: step_code = IS_HOLD;
            default: step_code = IS_BOOT;
        endcase
    endfunction

endpackage

// File: rtl/insn_fetch_if.sv
// rtl/insn_fetch_if.sv - program-memory read port and decoder presentation bundle
interface insn_fetch_if #(parameter int ADDR_W = insn_fetch_pkg::ADDR_W_DEF);

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [7:0]        mem_rdata;
    logic              mem_ack;
    logic [1:0]        len;
    logic [7:0]        insn;
    logic [7:0]        d1;
    logic [7:0]        d2;
    logic [7:0]        d3;
    logic [ADDR_W-1:0] insn_pc;
    logic [2:0]        is;
    logic              insn_valid;
    logic              insn_ready;
    logic              redirect;
    logic [ADDR_W-1:0] target;

    modport master (
        output mem_addr, mem_rd, insn, d1, d2, d3, insn_pc, is, insn_valid,
        input  mem_rdata, mem_ack, len, insn_ready, redirect, target
    );

    modport slave (
        input  mem_addr, mem_rd, insn, d1, d2, d3, insn_pc, is, insn_valid,
        output mem_rdata, mem_ack, len, insn_ready, redirect, target
    );

endinterface

// File: rtl/insn_fetch_byte_buf.sv
// rtl/insn_fetch_byte_buf.sv - 4x8 instruction gather register (opcode plus three operands)
module fetch_byte_buf (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [1:0] wr_idx,
    input  logic [7:0] wr_data,
    input  logic       clear,
    input  logic       freeze,
    output logic [7:0] b0,
    output logic [7:0] b1,
    output logic [7:0] b2,
    output logic [7:0] b3
);

    logic [7:0] bytes [4];

    // An opcode write lands in slot 0 and zeroes the operand slots in the same edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) bytes[i] <= 8'h00;
        end else if (wr_en && !freeze) begin
            for (int i = 0; i < 4; i++) begin
                if (clear)
                    bytes[i] <= (i == 0) ? wr_data : 8'h00;
                else if (wr_idx == 2'(i))
                    bytes[i] <= wr_data;
            end
        end
    end

    assign b0 = bytes[0];
    assign b1 = bytes[1];
    assign b2 = bytes[2];
    assign b3 = bytes[3];

endmodule

// File: rtl/insn_fetch.sv
// rtl/insn_fetch.sv - gathers opcode and operand bytes from program memory and presents them to decode
module insn_fetch
    import insn_fetch_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst,
    insn_fetch_if.master bus
);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] pc, pc_nx;
    logic [ADDR_W-1:0] insn_pc_r, insn_pc_nx;
    logic [1:0]        cnt, cnt_nx;
    logic [1:0]        k, k_nx;
    logic              drop_rd, drop_rd_nx;
    logic              mem_rd_int;
    logic              ack;
    logic              redir;
    logic              buf_wr;
    logic              buf_clear;
    logic [7:0]        b0, b1, b2, b3;

    // drop_rd idles the bus for one cycle after a redirect abandons an un-acked read
    assign mem_rd_int = (state == ST_OP || state == ST_OPND) && !drop_rd;
    assign ack        = mem_rd_int && bus.mem_ack;
    assign redir      = bus.redirect && (state != ST_BOOT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_BOOT;
            pc        <= RESET_PC;
            insn_pc_r <= RESET_PC;
            cnt       <= LEN_0;
            k         <= 2'd0;
            drop_rd   <= 1'b0;
        end else begin
            state     <= state_nx;
            pc        <= pc_nx;
            insn_pc_r <= insn_pc_nx;
            cnt       <= cnt_nx;
            k         <= k_nx;
            drop_rd   <= drop_rd_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        pc_nx      = pc;
        insn_pc_nx = insn_pc_r;
        cnt_nx     = cnt;
        k_nx       = k;
        drop_rd_nx = 1'b0;
        buf_wr     = 1'b0;
        buf_clear  = 1'b0;
        case (state)
            ST_BOOT: state_nx = ST_OP;
            ST_OP: if (ack) begin
                buf_wr     = 1'b1;
                buf_clear  = 1'b1;
                insn_pc_nx = pc;
                pc_nx      = pc + ADDR_W'(1);
                state_nx   = ST_LEN;
            end
            ST_LEN: begin
                cnt_nx   = bus.len;
                k_nx     = 2'd1;
                state_nx = (bus.len == LEN_0) ? ST_HOLD : ST_OPND;
            end
            ST_OPND: if (ack) begin
                buf_wr = 1'b1;
                pc_nx  = pc + ADDR_W'(1);
                if (k == cnt) state_nx = ST_HOLD;
                else          k_nx     = k + 2'd1;
            end
            ST_HOLD: if (bus.insn_ready) state_nx = ST_OP;
            default: state_nx = ST_BOOT;
        endcase
        // Redirect wins over everything gathered this cycle, including a coincident ack
        if (redir) begin
            state_nx   = ST_OP;
            pc_nx      = bus.target;
            insn_pc_nx = insn_pc_r;
            buf_wr     = 1'b0;
            drop_rd_nx = mem_rd_int && !bus.mem_ack;
        end
    end

    fetch_byte_buf u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (buf_wr),
        .wr_idx  (k),
        .wr_data (bus.mem_rdata),
        .clear   (buf_clear),
        .freeze  (state == ST_HOLD),
        .b0      (b0),
        .b1      (b1),
        .b2      (b2),
        .b3      (b3)
    );

    assign bus.mem_addr   = pc;
    assign bus.mem_rd     = mem_rd_int;
    assign bus.insn       = b0;
    assign bus.d1         = b1;
    assign bus.d2         = b2;
    assign bus.d3         = b3;
    assign bus.insn_pc    = insn_pc_r;
    assign bus.is         = step_code(state, k);
    assign bus.insn_valid = (state == ST_HOLD);

endmodule

// File: tb/tb_insn_fetch.sv
// tb/tb_insn_fetch.sv - scoreboard bench for insn_fetch with a byte-array program model
module tb_insn_fetch;

    localparam int AW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    insn_fetch_if #(.ADDR_W(AW)) bus();

    insn_fetch #(.ADDR_W(AW), .RESET_PC(16'h0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [7:0]  insn;
        logic [7:0]  d1;
        logic [7:0]  d2;
        logic [7:0]  d3;
        logic [15:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  mem [65536];
    logic [1:0]  len_tab [256];
    logic [15:0] model_pc = 16'h0000;

    int errors = 0;
    int checks = 0;
    int xfers  = 0;

    int wait_min   = 0;
    int wait_max   = 0;
    int ready_mode = 0;
    bit garbage    = 1'b0;
    bit rand_redir = 1'b0;
    bit dir_req    = 1'b0;
    logic [15:0] dir_tgt  = 16'h0000;
    bit          pend     = 1'b0;
    logic [15:0] pend_tgt = 16'h0000;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Program model: opcode at pc, operand count from the decoder table, operands follow with 16-bit wrap
    function automatic void top_up();
        exp_t        e;
        logic [7:0]  op;
        logic [1:0]  n;
        logic [15:0] a1, a2, a3;
        while (exp_q.size() < 4) begin
            op = mem[model_pc];
            n  = len_tab[op];
            a1 = model_pc + 16'd1;
            a2 = model_pc + 16'd2;
            a3 = model_pc + 16'd3;
            e.insn = op;
            e.pc   = model_pc;
            e.d1   = (n >= 2'd1) ? mem[a1] : 8'h00;
            e.d2   = (n >= 2'd2) ? mem[a2] : 8'h00;
            e.d3   = (n == 2'd3) ? mem[a3] : 8'h00;
            model_pc = model_pc + 16'(n) + 16'd1;
            exp_q.push_back(e);
        end
    endfunction

    // Memory responder and decoder length table
    int req_wait   = 0;
    bit req_active = 1'b0;
    always @(posedge clk) begin
        #1;
        if (!rst && bus.mem_rd) begin
            if (!req_active) begin
                req_active = 1'b1;
                req_wait   = int'($urandom_range(wait_max, wait_min));
            end
            if (req_wait == 0) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = mem[bus.mem_addr];
                req_active    = 1'b0;
            end else begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = 8'($urandom);
                req_wait--;
            end
        end else begin
            req_active    = 1'b0;
            bus.mem_ack   = garbage ? 1'($urandom) : 1'b0;
            bus.mem_rdata = 8'($urandom);
        end
        bus.len = (!rst && bus.is == 3'd2) ? len_tab[bus.insn] : 2'($urandom);
    end

    // Redirect / ready driver; a redirect flushes the expected stream one edge later
    always @(posedge clk) begin
        #1;
        if (rst) begin
            bus.redirect = 1'b0;
            pend         = 1'b0;
        end else begin
            if (pend) begin
                exp_q.delete();
                model_pc = pend_tgt;
                pend     = 1'b0;
            end
            bus.redirect = 1'b0;
            if (dir_req) begin
                bus.redirect = 1'b1;
                bus.target   = dir_tgt;
                dir_req      = 1'b0;
            end else if (rand_redir && $urandom_range(39, 0) == 0) begin
                bus.redirect = 1'b1;
                bus.target   = 16'($urandom);
            end
            if (bus.redirect) begin
                pend     = 1'b1;
                pend_tgt = bus.target;
            end
            top_up();
            case (ready_mode)
                0:       bus.insn_ready = 1'b1;
                1:       bus.insn_ready = ($urandom_range(99, 0) < 70);
                default: bus.insn_ready = 1'b0;
            endcase
        end
    end

    // Monitor: transfers against the scoreboard, plus read-hold protocol
    logic        prev_rd    = 1'b0;
    logic        prev_ack   = 1'b0;
    logic        prev_redir = 1'b0;
    logic [15:0] prev_addr  = 16'h0000;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_rd = 1'b0;
        end else begin
            if (prev_rd && !prev_ack) begin
                if (prev_redir) chk("rd_drop_after_redirect", bus.mem_rd, 1'b0);
                else            chk("rd_hold_addr", {bus.mem_rd, bus.mem_addr}, {1'b1, prev_addr});
            end
            if (bus.insn_valid && bus.insn_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL xfer_unexpected: pc=%0h insn=%0h with no instruction expected",
                             bus.insn_pc, bus.insn);
                end else begin
                    e = exp_q.pop_front();
                    chk("xfer", {bus.insn, bus.d1, bus.d2, bus.d3, bus.insn_pc}, e);
                end
                xfers++;
            end
            prev_rd    = bus.mem_rd;
            prev_ack   = bus.mem_ack;
            prev_redir = bus.redirect;
            prev_addr  = bus.mem_addr;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic release_rst();
        exp_q.delete();
        model_pc = 16'h0000;
        rst      = 1'b0;
    endtask

    task automatic wait_is(input logic [2:0] v);
        int n = 0;
        while (bus.is !== v && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("wait_is", bus.is, v);
    endtask

    task automatic wait_redir();
        int n = 0;
        while (bus.redirect !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("wait_redirect", bus.redirect, 1'b1);
    endtask

    task automatic wait_xfer(input int x0);
        int n = 0;
        while (xfers <= x0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("wait_xfer", xfers, x0 + 1);
    endtask

    task automatic measure(output int lat, output logic [23:0] steps);
        wait_is(3'd1);
        lat   = 0;
        steps = 24'd1;
        while (!bus.insn_valid && lat < 100) begin
            @(negedge clk);
            lat++;
            steps = {steps[20:0], bus.is};
        end
    endtask

    task automatic load_four_byte();
        mem[0] = 8'd13; mem[1] = 8'd100; mem[2] = 8'd50; mem[3] = 8'd64;
        len_tab[13] = 2'd3;
    endtask

    initial begin
        int          lat;
        int          x0;
        logic [23:0] steps;
        logic [23:0] exp2;
        logic [23:0] exp3;
        exp2 = {15'd0, 3'd1, 3'd2, 3'd6};
        exp3 = {6'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};

        bus.mem_ack    = 1'b0;
        bus.mem_rdata  = 8'h00;
        bus.len        = 2'd0;
        bus.insn_ready = 1'b0;
        bus.redirect   = 1'b0;
        bus.target     = 16'h0000;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) len_tab[i] = 2'($urandom);

        // Reset values, ignored acks during reset, redirect in BOOT ignored
        garbage = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_mem_addr", bus.mem_addr, 16'h0000);
        chk("rst_mem_rd", bus.mem_rd, 1'b0);
        chk("rst_insn", bus.insn, 8'h00);
        chk("rst_operands", {bus.d1, bus.d2, bus.d3}, 24'h0);
        chk("rst_insn_pc", bus.insn_pc, 16'h0000);
        chk("rst_is", bus.is, 3'd0);
        chk("rst_valid", bus.insn_valid, 1'b0);
        mem[0] = 8'd13;
        len_tab[13] = 2'd0;
        bus.redirect = 1'b1;
        bus.target   = 16'h1234;
        release_rst();
        chk("boot_rd_low", bus.mem_rd, 1'b0);
        @(negedge clk);
        chk("first_req", {bus.mem_rd, bus.mem_addr, bus.is}, {1'b1, 16'h0000, 3'd1});

        // 1-byte instruction, zero-wait
        measure(lat, steps);
        chk("lat_1byte", lat, 2);
        chk("steps_1byte", steps, exp2);
        @(negedge clk);
        chk("next_after_1byte", {bus.mem_rd, bus.mem_addr}, {1'b1, 16'h0001});

        // 4-byte instruction, zero-wait
        do_reset();
        load_four_byte();
        release_rst();
        measure(lat, steps);
        chk("lat_4byte", lat, 5);
        chk("steps_4byte", steps, exp3);
        @(negedge clk);
        chk("next_after_4byte", {bus.mem_rd, bus.mem_addr}, {1'b1, 16'h0004});

        // Wait states and backpressure
        do_reset();
        load_four_byte();
        wait_min   = 2;
        wait_max   = 2;
        ready_mode = 2;
        release_rst();
        begin
            int n = 0;
            while (!bus.insn_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        chk("bp_valid_rises", bus.insn_valid, 1'b1);
        x0 = xfers;
        repeat (4) begin
            @(negedge clk);
            chk("bp_valid_held", bus.insn_valid, 1'b1);
        end
        chk("bp_no_xfer", xfers, x0);
        ready_mode = 0;
        @(negedge clk);
        @(negedge clk);
        chk("bp_one_xfer", xfers, x0 + 1);
        chk("bp_valid_drops", bus.insn_valid, 1'b0);

        // Redirect in OPND after d1, coincident with an ack
        do_reset();
        load_four_byte();
        wait_min = 0;
        wait_max = 0;
        mem[16'h0200] = 8'h20;
        mem[16'h0201] = 8'h77;
        len_tab[8'h20] = 2'd1;
        release_rst();
        wait_is(3'd4);
        dir_tgt = 16'h0200;
        dir_req = 1'b1;
        wait_redir();
        x0 = xfers;
        @(negedge clk);
        chk("redir_valid_low", bus.insn_valid, 1'b0);
        chk("redir_req", {bus.mem_rd, bus.mem_addr}, {1'b1, 16'h0200});
        wait_xfer(x0);

        // Redirect while a read is still waiting: request drops for one cycle
        do_reset();
        wait_min = 3;
        wait_max = 3;
        release_rst();
        wait_is(3'd1);
        dir_tgt = 16'h0300;
        dir_req = 1'b1;
        wait_redir();
        @(negedge clk);
        chk("abandon_rd_low", bus.mem_rd, 1'b0);
        @(negedge clk);
        chk("abandon_refetch", {bus.mem_rd, bus.mem_addr}, {1'b1, 16'h0300});

        // Address wrap across FFFF
        do_reset();
        wait_min = 0;
        wait_max = 0;
        mem[16'hFFFE] = 8'h21;
        mem[16'hFFFF] = 8'hAA;
        mem[16'h0000] = 8'hBB;
        len_tab[8'h21] = 2'd2;
        len_tab[8'hBB] = 2'd0;
        release_rst();
        wait_is(3'd1);
        dir_tgt = 16'hFFFE;
        dir_req = 1'b1;
        wait_redir();
        x0 = xfers;
        wait_xfer(x0);
        @(negedge clk);
        chk("wrap_next_fetch", {bus.mem_addr, bus.is}, {16'h0001, 3'd1});

        // Randomized traffic with an asynchronous reset in the middle
        do_reset();
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) len_tab[i] = 2'($urandom);
        wait_min   = 0;
        wait_max   = 3;
        ready_mode = 1;
        rand_redir = 1'b1;
        x0 = xfers;
        release_rst();
        repeat (3000) @(negedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_outputs", {bus.mem_rd, bus.insn_valid, bus.is, bus.mem_addr},
            {1'b0, 1'b0, 3'd0, 16'h0000});
        repeat (2) @(negedge clk);
        release_rst();
        repeat (1500) @(negedge clk);
        rand_redir = 1'b0;
        chk("random_progress", (xfers - x0) > 100, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded its time limit");
        $fatal(1, "timeout");
    end

endmodule
